el2_dec_trigger_hit: RTL and testbench
======================================

EL2_DEC_TRIGGER_HIT -- requirements
Module: el2_dec_trigger_hit

Interface
REQ-001 SHALL have parameter: NUM_TRIG, 4, number of triggers; only value 4 is supported.
REQ-002 SHALL have ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- trig_match_d  in  4  per-trigger match from the decode-stage trigger comparator.
- i0_valid_d  in  1  valid instruction in D.
- pipe_adv  in  1  pipeline advance enable; 0 holds all stages.
- flush  in  1  kill the instructions in D and X.
- dbg_mode  in  1  core is in debug mode.
- trig_chain  in  4  per-trigger chain bit; only bits 0 and 2 are used.
- trig_action  in  4  per-trigger action: 0 = breakpoint exception, 1 = debug halt.
- hit_clr  in  4  per-trigger sticky-hit clear, from the CSR write.
- trig_hit_r  out  4  qualified hits of the retiring instruction.
- trig_bkpt_r  out  1  take a breakpoint exception at R.
- trig_halt_r  out  1  enter debug halt at R.
- trig_hit_sts  out  4  sticky hit status.

Function
REQ-003 SHALL register the D-stage match into stage X, and X into stage R, only on cycles where pipe_adv=1.
REQ-004 SHALL capture x_vld <= i0_valid_d & ~flush & ~dbg_mode on advance.
REQ-005 SHALL capture x_hit <= qualified D match (REQ-006) on advance.
REQ-006 Qualified D match per pair (0,1) and (2,3):
- If trig_chain[lo]=1: both bits of the pair SHALL be set only when both raw matches are 1; otherwise both bits SHALL be 0.
- If trig_chain[lo]=0: each bit SHALL equal its raw match.
REQ-007 SHALL advance X to R with r_vld <= x_vld & ~flush and r_hit <= x_hit.
REQ-008 While pipe_adv=0, x_vld, x_hit, r_vld and r_hit SHALL hold their values; flush SHALL still clear x_vld and r_vld on the next edge.
REQ-009 SHALL drive trig_hit_r = r_hit & {4{r_vld}} combinationally; latency SHALL be 2 clocks from D match to R output.
REQ-010 SHALL assert trig_halt_r when any trig_hit_r[i]=1 with trig_action[i]=1.
REQ-011 SHALL assert trig_bkpt_r when any trig_hit_r bit is set and trig_halt_r=0; the two outputs SHALL never be high together.
REQ-012 SHALL sample trig_action at R, not at D.
REQ-013 SHALL set trig_hit_sts[i] on the edge after trig_hit_r[i]=1.
REQ-014 SHALL clear trig_hit_sts[i] on hit_clr[i]; if set and clear occur in the same cycle, set SHALL win.
REQ-015 Flush in cycle t SHALL NOT alter the R outputs of cycle t; r_vld SHALL be 0 in cycle t+1.
REQ-016 Each stage SHALL hold at most one instruction; no buffering beyond X and R.

Reset
REQ-017 On rst SHALL immediately clear x_vld, x_hit, r_vld, r_hit and trig_hit_sts to 0; all outputs SHALL read 0.
REQ-018 Instructions in flight when rst asserts SHALL be discarded; the first valid R output after reset deassertion SHALL require a fresh D capture plus two advances.

Configuration
REQ-019 With EL2_TRIGGER_CHAIN_EN defined, chaining per REQ-006 SHALL be built.
REQ-020 With EL2_TRIGGER_CHAIN_EN undefined, trig_chain SHALL be ignored and each qualified bit SHALL equal its raw match.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Basic: trig_match_d=4'b0001, i0_valid_d=1, action=0, pipe_adv=1 -> trig_hit_r=0001 and trig_bkpt_r=1 two cycles later; trig_hit_sts=0001 the following cycle.
- Chain: chain[0]=1, match=0001 -> no hit at R. Then match=0011 -> trig_hit_r=0011. With EL2_TRIGGER_CHAIN_EN undefined, match=0001 -> trig_hit_r=0001.
- Priority: match=0101, action=0100 -> trig_halt_r=1 and trig_bkpt_r=0.
- Stall and flush: hit captured in X, then pipe_adv=0 for 3 cycles -> R output delayed 3 cycles. A flush while the hit is in X -> no R output ever.
- Sticky set/clear collision: hit_clr=0001 in the same cycle as trig_hit_r=0001 -> trig_hit_sts[0] stays 1. hit_clr alone -> trig_hit_sts[0] becomes 0.
- Reset and debug mode: rst asserted with r_vld=1 -> trig_hit_r=0 immediately. dbg_mode=1 with match=1111 -> no R output.

Source files
------------

// File: rtl/el2_dec_trigger_hit.sv
// el2_dec_trigger_hit: D->X->R trigger hit pipeline with sticky status; pair chaining built only with EL2_TRIGGER_CHAIN_EN
module el2_dec_trigger_hit #(
  parameter int NUM_TRIG = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_TRIG-1:0] trig_match_d,
  input  logic                i0_valid_d,
  input  logic                pipe_adv,
  input  logic                flush,
  input  logic                dbg_mode,
  input  logic [NUM_TRIG-1:0] trig_chain,
  input  logic [NUM_TRIG-1:0] trig_action,
  input  logic [NUM_TRIG-1:0] hit_clr,
  output logic [NUM_TRIG-1:0] trig_hit_r,
  output logic                trig_bkpt_r,
  output logic                trig_halt_r,
  output logic [NUM_TRIG-1:0] trig_hit_sts
);
  logic [NUM_TRIG-1:0] q_d, x_hit, r_hit;
  logic                x_vld, r_vld, unused_chain;
`ifdef EL2_TRIGGER_CHAIN_EN
  // a chained pair reports a hit on both members only when both match
  always_comb begin
    q_d[1:0] = trig_chain[0] ? {2{&trig_match_d[1:0]}} : trig_match_d[1:0];
    q_d[3:2] = trig_chain[2] ? {2{&trig_match_d[3:2]}} : trig_match_d[3:2];
    unused_chain = trig_chain[1] ^ trig_chain[3];
  end
`else
  // without chaining every trigger stands alone
  always_comb begin
    q_d = trig_match_d;
    unused_chain = ^trig_chain;
  end
`endif
  // X and R stages hold on stall, but flush always kills their valids
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_vld <= 1'b0;
      x_hit <= '0;
      r_vld <= 1'b0;
      r_hit <= '0;
      trig_hit_sts <= '0;
    end else begin
      x_vld <= pipe_adv ? (i0_valid_d & ~dbg_mode & ~flush) : (x_vld & ~flush);
      x_hit <= pipe_adv ? q_d : x_hit;
      r_vld <= (pipe_adv ? x_vld : r_vld) & ~flush;
      r_hit <= pipe_adv ? x_hit : r_hit;
      trig_hit_sts <= trig_hit_r | (trig_hit_sts & ~hit_clr);
    end
  end
  // halt outranks breakpoint; action is taken from the value seen at R
  always_comb begin
    trig_hit_r = r_hit & {NUM_TRIG{r_vld}};
    trig_halt_r = |(trig_hit_r & trig_action);
    trig_bkpt_r = |trig_hit_r & ~trig_halt_r;
  end
endmodule

// File: tb/tb_el2_dec_trigger_hit.sv
// tb_el2_dec_trigger_hit: directed scenarios plus randomized run against a behavioural model
module tb_el2_dec_trigger_hit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] trig_match_d = '0, trig_chain = '0, trig_action = '0, hit_clr = '0;
  logic i0_valid_d = 1'b0, pipe_adv = 1'b1, flush = 1'b0, dbg_mode = 1'b0;
  logic [3:0] trig_hit_r, trig_hit_sts;
  logic trig_bkpt_r, trig_halt_r;
  int checks = 0;
  int errors = 0;

  el2_dec_trigger_hit #(.NUM_TRIG(4)) dut (
    .clk(clk), .rst(rst), .trig_match_d(trig_match_d), .i0_valid_d(i0_valid_d),
    .pipe_adv(pipe_adv), .flush(flush), .dbg_mode(dbg_mode), .trig_chain(trig_chain),
    .trig_action(trig_action), .hit_clr(hit_clr), .trig_hit_r(trig_hit_r),
    .trig_bkpt_r(trig_bkpt_r), .trig_halt_r(trig_halt_r), .trig_hit_sts(trig_hit_sts)
  );

  always #5 clk = ~clk;

  // behavioural model: an instruction is a (valid, hits) record moving through two slots
  typedef struct packed { bit v; bit [3:0] h; } slot_t;
  slot_t m_x, m_r;
  bit [3:0] m_sts;

  function automatic bit [3:0] qualify(input bit [3:0] m, input bit [3:0] c);
    bit [3:0] q = m;
`ifdef EL2_TRIGGER_CHAIN_EN
    for (int p = 0; p < 4; p += 2)
      if (c[p]) begin
        q[p] = m[p] && m[p+1];
        q[p+1] = q[p];
      end
`endif
    return q;
  endfunction

  function automatic bit [3:0] exp_hit();
    return m_r.v ? m_r.h : 4'b0;
  endfunction

  function automatic bit exp_halt();
    bit [3:0] h = exp_hit();
    for (int i = 0; i < 4; i++)
      if (h[i] && trig_action[i]) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_x <= '0;
      m_r <= '0;
      m_sts <= '0;
    end else begin
      m_sts <= exp_hit() | (m_sts & ~hit_clr);
      if (flush) begin
        m_x.v <= 1'b0;
        m_r.v <= 1'b0;
        if (pipe_adv) begin
          m_x.h <= qualify(trig_match_d, trig_chain);
          m_r.h <= m_x.h;
        end
      end else if (pipe_adv) begin
        m_x <= '{v: i0_valid_d && !dbg_mode, h: qualify(trig_match_d, trig_chain)};
        m_r <= m_x;
      end
    end
  end

  task automatic idle();
    trig_match_d = '0; i0_valid_d = 0; pipe_adv = 1; flush = 0; dbg_mode = 0;
    trig_chain = '0; trig_action = '0; hit_clr = '0;
  endtask

  task automatic issue(input logic [3:0] m);
    trig_match_d = m; i0_valid_d = 1;
    @(negedge clk);
    trig_match_d = '0; i0_valid_d = 0;
  endtask

  task automatic drain();
    idle();
    repeat (2) @(negedge clk);
    hit_clr = 4'hf;
    repeat (2) @(negedge clk);
    hit_clr = '0;
  endtask

  task automatic test_reset();
    checks++;
    if ({trig_hit_r, trig_bkpt_r, trig_halt_r, trig_hit_sts} !== 10'b0) begin
      errors++; $display("FAIL reset_outputs: got hit=%b bkpt=%b halt=%b sts=%b, want all 0", trig_hit_r, trig_bkpt_r, trig_halt_r, trig_hit_sts);
    end
  endtask

  task automatic test_basic();
    issue(4'b0001);
    @(negedge clk);
    checks++;
    if (trig_hit_r !== 4'b0001 || trig_bkpt_r !== 1'b1 || trig_halt_r !== 1'b0) begin
      errors++; $display("FAIL basic_r: got hit=%b bkpt=%b halt=%b, want 0001 1 0", trig_hit_r, trig_bkpt_r, trig_halt_r);
    end
    @(negedge clk);
    checks++;
    if (trig_hit_sts !== 4'b0001 || trig_hit_r !== 4'b0000) begin
      errors++; $display("FAIL basic_sts: got sts=%b hit=%b, want 0001 0000", trig_hit_sts, trig_hit_r);
    end
    drain();
  endtask

  task automatic test_chain();
    logic [3:0] want;
`ifdef EL2_TRIGGER_CHAIN_EN
    want = 4'b0000;
`else
    want = 4'b0001;
`endif
    trig_chain = 4'b0001;
    issue(4'b0001);
    @(negedge clk);
    checks++;
    if (trig_hit_r !== want) begin
      errors++; $display("FAIL chain_single: got %b, want %b", trig_hit_r, want);
    end
    issue(4'b0011);
    @(negedge clk);
    checks++;
    if (trig_hit_r !== 4'b0011) begin
      errors++; $display("FAIL chain_pair: got %b, want 0011", trig_hit_r);
    end
    drain();
  endtask

  task automatic test_priority();
    trig_action = 4'b0100;
    issue(4'b0101);
    @(negedge clk);
    checks++;
    if (trig_hit_r !== 4'b0101 || trig_halt_r !== 1'b1 || trig_bkpt_r !== 1'b0) begin
      errors++; $display("FAIL priority: got hit=%b halt=%b bkpt=%b, want 0101 1 0", trig_hit_r, trig_halt_r, trig_bkpt_r);
    end
    trig_action = 4'b0000;
    #1;
    checks++;
    if (trig_halt_r !== 1'b0 || trig_bkpt_r !== 1'b1) begin
      errors++; $display("FAIL action_at_r: got halt=%b bkpt=%b, want 0 1", trig_halt_r, trig_bkpt_r);
    end
    drain();
  endtask

  task automatic test_stall_flush();
    issue(4'b0001);
    pipe_adv = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (trig_hit_r !== 4'b0000) begin
        errors++; $display("FAIL stall_hold[%0d]: got %b, want 0000", i, trig_hit_r);
      end
    end
    pipe_adv = 1;
    @(negedge clk);
    checks++;
    if (trig_hit_r !== 4'b0001) begin
      errors++; $display("FAIL stall_release: got %b, want 0001", trig_hit_r);
    end
    drain();
    issue(4'b0010);
    flush = 1;
    @(negedge clk);
    flush = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (trig_hit_r !== 4'b0000) begin
        errors++; $display("FAIL flush_x[%0d]: got %b, want 0000", i, trig_hit_r);
      end
      @(negedge clk);
    end
    issue(4'b1000);
    pipe_adv = 0; flush = 1;
    @(negedge clk);
    flush = 0; pipe_adv = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (trig_hit_r !== 4'b0000 || trig_hit_sts !== 4'b0000) begin
      errors++; $display("FAIL flush_stalled: got hit=%b sts=%b, want 0000 0000", trig_hit_r, trig_hit_sts);
    end
    drain();
  endtask

  task automatic test_sticky();
    issue(4'b0001);
    @(negedge clk);
    hit_clr = 4'b0001;
    @(negedge clk);
    checks++;
    if (trig_hit_sts[0] !== 1'b1) begin
      errors++; $display("FAIL sticky_set_wins: got %b, want 1", trig_hit_sts[0]);
    end
    @(negedge clk);
    hit_clr = 4'b0000;
    checks++;
    if (trig_hit_sts[0] !== 1'b0) begin
      errors++; $display("FAIL sticky_clear: got %b, want 0", trig_hit_sts[0]);
    end
    drain();
  endtask

  task automatic test_reset_dbg();
    issue(4'b0001);
    issue(4'b0100);
    checks++;
    if (trig_hit_r !== 4'b0001) begin
      errors++; $display("FAIL pre_reset: got %b, want 0001", trig_hit_r);
    end
    rst = 1;
    #1;
    checks++;
    if (trig_hit_r !== 4'b0000 || trig_bkpt_r !== 1'b0) begin
      errors++; $display("FAIL async_reset: got hit=%b bkpt=%b, want 0000 0", trig_hit_r, trig_bkpt_r);
    end
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (trig_hit_r !== 4'b0000 || trig_hit_sts !== 4'b0000) begin
      errors++; $display("FAIL post_reset_discard: got hit=%b sts=%b, want 0000 0000", trig_hit_r, trig_hit_sts);
    end
    dbg_mode = 1;
    issue(4'b1111);
    dbg_mode = 0;
    @(negedge clk);
    checks++;
    if (trig_hit_r !== 4'b0000) begin
      errors++; $display("FAIL dbg_mode: got %b, want 0000", trig_hit_r);
    end
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      checks++;
      if (trig_hit_r !== exp_hit() || trig_halt_r !== exp_halt() ||
          trig_bkpt_r !== ((exp_hit() != 0) && !exp_halt()) || trig_hit_sts !== m_sts) begin
        errors++; $display("FAIL random[%0d]: got hit=%b halt=%b bkpt=%b sts=%b, want hit=%b halt=%b sts=%b",
                           n, trig_hit_r, trig_halt_r, trig_bkpt_r, trig_hit_sts, exp_hit(), exp_halt(), m_sts);
      end
      trig_match_d = 4'($urandom);
      i0_valid_d = ($urandom_range(0, 3) != 0);
      pipe_adv = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      dbg_mode = ($urandom_range(0, 9) == 0);
      trig_chain = 4'($urandom);
      trig_action = 4'($urandom);
      hit_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      rst = ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end
    rst = 0;
    idle();
  endtask

  initial begin
    idle();
    repeat (2) @(negedge clk);
    test_reset();
    rst = 0;
    @(negedge clk);
    test_basic();
    test_chain();
    test_priority();
    test_stall_flush();
    test_sticky();
    test_reset_dbg();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
